// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory for the core's load/store port.
// Requests go through a req/ack handshake with a fixed number of wait states.
// Misaligned or out-of-range accesses are answered with an error instead of
// touching the array.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemAck,
  output logic        MemErr,
  output logic        Busy
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [IDX_W-1:0] idxQ;
  logic             writeQ;
  logic [31:0]      wdataQ;
  logic             errQ;
  logic [31:0]      rdataQ;

  logic             captureEn;
  logic             enterResp;
  logic             liveErr;
  logic [IDX_W-1:0] liveIdx;
  logic [IDX_W-1:0] commitIdx;
  logic             commitWrite;
  logic             commitErr;
  logic [31:0]      commitData;

  logic [31:0] memArray [DEPTH_WORDS];

  assign liveErr = (Addr[1:0] != 2'b00) || (Addr[31:2] >= DEPTH_LIM);
  assign liveIdx = Addr[IDX_W+1:2];

  // With zero wait states the commit edge is also the capture edge, so the
  // commit has to take the live inputs rather than the not-yet-latched copies.
  always_comb begin
    if (stateQ == ST_IDLE) begin
      commitIdx   = liveIdx;
      commitWrite = MemWrite;
      commitErr   = liveErr;
      commitData  = WriteData;
    end else begin
      commitIdx   = idxQ;
      commitWrite = writeQ;
      commitErr   = errQ;
      commitData  = wdataQ;
    end
  end

  // Handshake FSM: IDLE waits for a request, WAIT counts down the wait states,
  // RESP is the single ack cycle before returning to IDLE.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    captureEn = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (MemReq) begin
          captureEn = 1'b1;
          cntD      = CNT_LOAD;
          stateD    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cntQ == '0) begin
          stateD = ST_RESP;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      ST_RESP: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  assign enterResp = (stateD == ST_RESP) && (stateQ != ST_RESP);

  // State, counter and load data; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= ST_IDLE;
      cntQ   <= '0;
      rdataQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (enterResp && !commitWrite) begin
        rdataQ <= commitErr ? ERR_DATA : memArray[commitIdx];
      end
    end
  end

  // Request capture: everything the access needs is frozen here so later
  // input wiggles on the bus cannot change the outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idxQ   <= '0;
      writeQ <= 1'b0;
      wdataQ <= '0;
      errQ   <= 1'b0;
    end else if (captureEn) begin
      idxQ   <= liveIdx;
      writeQ <= MemWrite;
      wdataQ <= WriteData;
      errQ   <= liveErr;
    end
  end

  // Storage array (not reset); a store commits on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enterResp && commitWrite && !commitErr) begin
      memArray[commitIdx] <= commitData;
    end
  end

  assign ReadData = rdataQ;
  assign MemAck   = (stateQ == ST_RESP);
  assign MemErr   = (stateQ == ST_RESP) && errQ;
  assign Busy     = (stateQ != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: drives two responders (2 wait states and 0 wait
// states) through directed loads/stores and checks every ack against a
// scoreboard of expected results built from a small memory model.
module tb_data_mem_responder;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetSig  [2];
  logic        memReq    [2];
  logic        memWrite  [2];
  logic [31:0] addr      [2];
  logic [31:0] writeData [2];
  logic [31:0] readData  [2];
  logic        memAck    [2];
  logic        memErr    [2];
  logic        busy      [2];

  logic [31:0] modelMem [2][256];
  logic [31:0] lastRd   [2];
  exp_t        sbq [$];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          t1, t2;

  // Free-running clock shared by both responders.
  always #5 clock = ~clock;

  // Cycle counter used to measure ack spacing.
  always @(posedge clock) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ERR_DATA(ERR_DATA)) dutW2 (
    .clk(clock), .reset(resetSig[0]), .MemReq(memReq[0]), .MemWrite(memWrite[0]),
    .Addr(addr[0]), .WriteData(writeData[0]), .ReadData(readData[0]),
    .MemAck(memAck[0]), .MemErr(memErr[0]), .Busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ERR_DATA(ERR_DATA)) dutW0 (
    .clk(clock), .reset(resetSig[1]), .MemReq(memReq[1]), .MemWrite(memWrite[1]),
    .Addr(addr[1]), .WriteData(writeData[1]), .ReadData(readData[1]),
    .MemAck(memAck[1]), .MemErr(memErr[1]), .Busy(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request and push what the model says the ack must carry.
  task automatic applyStimulus(input int s, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input string tag);
    exp_t e;
    e.tag = tag;
    e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    if (w) begin
      if (!e.err) modelMem[s][a[9:2]] = d;
      e.data = lastRd[s];
    end else begin
      e.data = e.err ? ERR_DATA : modelMem[s][a[9:2]];
      lastRd[s] = e.data;
    end
    sbq.push_back(e);
    memReq[s]    = 1'b1;
    memWrite[s]  = w;
    addr[s]      = a;
    writeData[s] = d;
  endtask

  task automatic popCheck(input int s);
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      checkOutput({e.tag, "_err"}, 32'(memErr[s]), 32'(e.err));
      checkOutput({e.tag, "_data"}, readData[s], e.data);
    end
  endtask

  // Let the capture edge happen, then count cycles to the ack (bounded).
  task automatic waitAck(input int s, input bit toggle);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    @(posedge clock);
    while (!got && k < 20) begin
      @(negedge clock);
      memReq[s] = 1'b0;
      if (toggle && k == 0) begin
        addr[s]      = ~addr[s];
        writeData[s] = ~writeData[s];
      end
      if (memAck[s]) begin
        got = 1'b1;
      end else begin
        if (k == 0) checkOutput("busy_in_wait", 32'(busy[s]), 32'd1);
        k++;
      end
    end
    checkOutput("ack_latency", 32'(k), (s == 0) ? 32'd2 : 32'd0);
    popCheck(s);
    @(negedge clock);
    checkOutput("ack_one_cycle", 32'(memAck[s]), 32'd0);
  endtask

  task automatic doReq(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string tag, input bit toggle);
    applyStimulus(s, w, a, d, tag);
    waitAck(s, toggle);
  endtask

  // Directed sequence: reset, basic store/load, back-to-back, errors,
  // input changes during WAIT, and reset during WAIT.
  initial begin
    for (int i = 0; i < 2; i++) begin
      resetSig[i] = 1'b1; memReq[i] = 1'b0; memWrite[i] = 1'b0;
      addr[i] = '0; writeData[i] = '0; lastRd[i] = '0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_ack", 32'(memAck[i]), 32'd0);
      checkOutput("reset_err", 32'(memErr[i]), 32'd0);
      checkOutput("reset_busy", 32'(busy[i]), 32'd0);
      checkOutput("reset_rdata", readData[i], 32'd0);
    end
    repeat (2) @(negedge clock);
    resetSig[0] = 1'b0;
    resetSig[1] = 1'b0;
    @(negedge clock);

    doReq(0, 1'b1, 32'h10, 32'h12345678, "st_10", 1'b0);
    doReq(0, 1'b0, 32'h10, 32'h0, "ld_10", 1'b0);

    applyStimulus(1, 1'b1, 32'h3FC, 32'hA5A5A5A5, "b2b_st");
    @(posedge clock);
    @(negedge clock);
    checkOutput("b2b_ack1", 32'(memAck[1]), 32'd1);
    t1 = cyc;
    popCheck(1);
    applyStimulus(1, 1'b0, 32'h3FC, 32'h0, "b2b_ld");
    @(negedge clock);
    checkOutput("b2b_gap_ack", 32'(memAck[1]), 32'd0);
    checkOutput("b2b_gap_busy", 32'(busy[1]), 32'd0);
    @(negedge clock);
    checkOutput("b2b_ack2", 32'(memAck[1]), 32'd1);
    t2 = cyc;
    popCheck(1);
    memReq[1] = 1'b0;
    checkOutput("b2b_period", 32'(t2 - t1), 32'd2);
    @(negedge clock);

    doReq(0, 1'b1, 32'h11, 32'h55555555, "st_mis", 1'b0);
    doReq(0, 1'b0, 32'h10, 32'h0, "ld_10_after_mis", 1'b0);
    doReq(0, 1'b0, 32'h13, 32'h0, "ld_mis", 1'b0);

    doReq(0, 1'b1, 32'h0, 32'h0F0F0F0F, "st_0", 1'b0);
    doReq(0, 1'b1, 32'h400, 32'h00000BAD, "st_oor", 1'b0);
    doReq(0, 1'b0, 32'h400, 32'h0, "ld_oor", 1'b0);
    doReq(0, 1'b0, 32'h0, 32'h0, "ld_0_after_oor", 1'b0);
    doReq(0, 1'b0, 32'h10, 32'h0, "ld_10_after_oor", 1'b0);
    doReq(1, 1'b0, 32'h3FC, 32'h0, "w0_ld_3fc", 1'b0);
    doReq(1, 1'b0, 32'h400, 32'h0, "w0_ld_oor", 1'b0);

    doReq(0, 1'b1, 32'h44, 32'h11111111, "st_44", 1'b0);
    doReq(0, 1'b1, 32'h40, 32'hCAFEF00D, "st_40_toggled", 1'b1);
    doReq(0, 1'b0, 32'h40, 32'h0, "ld_40", 1'b1);
    doReq(0, 1'b0, 32'h44, 32'h0, "ld_44", 1'b0);

    doReq(0, 1'b1, 32'h20, 32'h00000001, "st_20", 1'b0);
    memReq[0] = 1'b1; memWrite[0] = 1'b1; addr[0] = 32'h20; writeData[0] = 32'hFFFF0000;
    @(posedge clock);
    @(negedge clock);
    memReq[0] = 1'b0;
    checkOutput("abort_busy_before", 32'(busy[0]), 32'd1);
    resetSig[0] = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    checkOutput("abort_rdata", readData[0], 32'd0);
    lastRd[0] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 2) resetSig[0] = 1'b0;
      checkOutput("abort_no_ack", 32'(memAck[0]), 32'd0);
    end
    doReq(0, 1'b0, 32'h20, 32'h0, "ld_20_after_abort", 1'b0);

    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
